acc_sequencer: RTL and testbench

ACC_SEQUENCER -- requirements
Module: acc_sequencer

---
 rtl/acc_sequencer_if.sv | 24 ++
 rtl/acc_sequencer.sv | 106 ++++++++++
 tb/tb_acc_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/acc_sequencer_if.sv
// Handshake and result bundle for acc_sequencer: run control, sample stream and accumulator outputs.
interface acc_sequencer_if;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic       ack;
    logic [7:0] acc1_out;
    logic [7:0] acc2_out;
    logic [7:0] acc3_out;

    modport master (
        output start, len, in_valid, in_data, ack,
        input  in_ready, busy, done, acc1_out, acc2_out, acc3_out
    );

    modport slave (
        input  start, len, in_valid, in_data, ack,
        output in_ready, busy, done, acc1_out, acc2_out, acc3_out
    );
endinterface

// File: rtl/acc_sequencer.sv
// Three-stage cascaded accumulator over a run of N 4-bit samples (IDLE/RUN/DONE handshake).
// Define ACC_SEQ_SAT_EN to make every accumulation stage saturate at 255 instead of wrapping.
module acc_sequencer (
    input  logic            clk,
    input  logic            reset,
    acc_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [4:0] count_reg, count_next;
    logic [7:0] acc1_reg, acc1_next;
    logic [7:0] acc2_reg, acc2_next;
    logic [7:0] acc3_reg, acc3_next;

    logic       accept;
    logic [7:0] acc1_upd, acc2_upd, acc3_upd;

    function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
`ifdef ACC_SEQ_SAT_EN
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
`else
        return a + b;
`endif
    endfunction

    // Each stage consumes the already-updated (and, if enabled, saturated) value of the previous one.
    always_comb begin
        acc1_upd = add8(acc1_reg, {4'b0000, bus.in_data});
        acc2_upd = add8(acc2_reg, acc1_upd);
        acc3_upd = add8(add8(acc3_reg, acc1_upd), acc2_upd);
    end

    assign accept = bus.in_valid && (state_reg == RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= 5'd0;
            acc1_reg  <= 8'd0;
            acc2_reg  <= 8'd0;
            acc3_reg  <= 8'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            acc1_reg  <= acc1_next;
            acc2_reg  <= acc2_next;
            acc3_reg  <= acc3_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        acc1_next  = acc1_reg;
        acc2_next  = acc2_reg;
        acc3_next  = acc3_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    acc1_next  = 8'd0;
                    acc2_next  = 8'd0;
                    acc3_next  = 8'd0;
                    // A length of zero encodes a full run of 16 samples.
                    count_next = (bus.len == 4'd0) ? 5'd16 : {1'b0, bus.len};
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    acc1_next  = acc1_upd;
                    acc2_next  = acc2_upd;
                    acc3_next  = acc3_upd;
                    count_next = count_reg - 5'd1;
                    if (count_reg == 5'd1) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.in_ready = (state_reg == RUN);
    assign bus.busy     = (state_reg == RUN) || (state_reg == DONE);
    assign bus.done     = (state_reg == DONE);
    assign bus.acc1_out = acc1_reg;
    assign bus.acc2_out = acc2_reg;
    assign bus.acc3_out = acc3_reg;

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed-vector bench for acc_sequencer; expected values are hand-computed constants.
module tb_acc_sequencer;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    acc_sequencer_if bus ();

    acc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic check_flags(input string tag, input logic rdy, input logic bsy, input logic dn);
        check({tag, ".in_ready"}, {15'd0, bus.in_ready}, {15'd0, rdy});
        check({tag, ".busy"},     {15'd0, bus.busy},     {15'd0, bsy});
        check({tag, ".done"},     {15'd0, bus.done},     {15'd0, dn});
    endtask

    task automatic check_acc(input string tag, input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3);
        check({tag, ".acc1"}, {8'd0, bus.acc1_out}, {8'd0, a1});
        check({tag, ".acc2"}, {8'd0, bus.acc2_out}, {8'd0, a2});
        check({tag, ".acc3"}, {8'd0, bus.acc3_out}, {8'd0, a3});
    endtask

    // Called at a negedge in IDLE; returns at the following negedge.
    task automatic start_run(input logic [3:0] n);
        bus.start = 1'b1;
        bus.len   = n;
        @(negedge clk);
        bus.start = 1'b0;
        bus.len   = 4'd0;
        check_flags("start", 1'b1, 1'b1, 1'b0);
        check_acc("start_clear", 8'd0, 8'd0, 8'd0);
    endtask

    // Presents one sample for exactly one edge, with a bounded wait for in_ready.
    task automatic push(input logic [3:0] d);
        int waited;
        waited = 0;
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("push_ready", {15'd0, bus.in_ready}, 16'd1);
        if (bus.in_ready) begin
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 4'd0;
        end
    endtask

    task automatic pulse_ack();
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.len      = 4'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 4'd0;
        bus.ack      = 1'b0;

        // Reset state
        #3;
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        check_acc("reset", 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_flags("idle", 1'b0, 1'b0, 1'b0);

        // Back-to-back run, len=3, samples 1,2,3
        start_run(4'd3);
        push(4'd1);
        check_acc("b2b_s1", 8'd1, 8'd1, 8'd2);
        push(4'd2);
        check_acc("b2b_s2", 8'd3, 8'd4, 8'd9);
        push(4'd3);
        check_flags("b2b_done", 1'b0, 1'b1, 1'b1);
        check_acc("b2b_final", 8'd6, 8'd10, 8'd25);
        @(negedge clk);
        check_flags("b2b_hold", 1'b0, 1'b1, 1'b1);
        pulse_ack();
        check_flags("b2b_ack", 1'b0, 1'b0, 1'b0);
        check_acc("idle_hold", 8'd6, 8'd10, 8'd25);

        // Same run with two idle cycles between samples
        start_run(4'd3);
        push(4'd1);
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            check("gap1.in_ready", {15'd0, bus.in_ready}, 16'd1);
            check_acc("gap1_hold", 8'd1, 8'd1, 8'd2);
        end
        push(4'd2);
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            check("gap2.in_ready", {15'd0, bus.in_ready}, 16'd1);
            check_acc("gap2_hold", 8'd3, 8'd4, 8'd9);
        end
        push(4'd3);
        check_flags("gap_done", 1'b0, 1'b1, 1'b1);
        check_acc("gap_final", 8'd6, 8'd10, 8'd25);
        pulse_ack();

        // Stray start/ack in the wrong states
        pulse_ack();
        check_flags("ack_in_idle", 1'b0, 1'b0, 1'b0);
        start_run(4'd3);
        push(4'd1);
        bus.start = 1'b1;
        bus.len   = 4'd1;
        bus.ack   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.len   = 4'd0;
        bus.ack   = 1'b0;
        check_flags("stray_in_run", 1'b1, 1'b1, 1'b0);
        check_acc("stray_in_run", 8'd1, 8'd1, 8'd2);
        push(4'd2);
        check("count_kept.done", {15'd0, bus.done}, 16'd0);
        push(4'd3);
        check_flags("stray_done", 1'b0, 1'b1, 1'b1);
        bus.start = 1'b1;
        bus.len   = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        check_flags("start_in_done", 1'b0, 1'b1, 1'b1);
        check_acc("start_in_done", 8'd6, 8'd10, 8'd25);
        bus.start = 1'b1;
        bus.len   = 4'd2;
        bus.ack   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        check_flags("start_ack_done", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_flags("no_new_run", 1'b0, 1'b0, 1'b0);
        check_acc("no_new_run", 8'd6, 8'd10, 8'd25);

        // len=0 means 16 samples of 15
        start_run(4'd0);
        for (int k = 0; k < 15; k++) push(4'd15);
        check_flags("len0_15th", 1'b1, 1'b1, 1'b0);
        push(4'd15);
        check_flags("len0_done", 1'b0, 1'b1, 1'b1);
`ifdef ACC_SEQ_SAT_EN
        check_acc("len0_final", 8'd240, 8'd255, 8'd255);
`else
        check_acc("len0_final", 8'd240, 8'd248, 8'd200);
`endif
        pulse_ack();

        // Asynchronous reset mid-run
        start_run(4'd3);
        push(4'd1);
        push(4'd2);
        #2;
        reset = 1'b0;
        #1;
        check_flags("async_rst", 1'b0, 1'b0, 1'b0);
        check_acc("async_rst", 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_flags("post_rst_idle", 1'b0, 1'b0, 1'b0);
        start_run(4'd1);
        push(4'd5);
        check_flags("post_rst_done", 1'b0, 1'b1, 1'b1);
        check_acc("post_rst_final", 8'd5, 8'd5, 8'd10);
        pulse_ack();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
